// File: rtl/csi_rx_pkg.sv
// Shared state encodings and default timing constants for the CSI-2 receive link controller.
package csi_rx_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_STARTUP = 3'd1,
    ST_WAIT_LP = 3'd2,
    ST_ARMED   = 3'd3,
    ST_ACTIVE  = 3'd4,
    ST_RECOVER = 3'd5
  } link_state_t;

  localparam int DEF_LANES          = 2;
  localparam int DEF_STARTUP_CYCLES = 1024;
  localparam int DEF_LP_MIN         = 16;
  localparam int DEF_SYNC_TIMEOUT   = 65535;
  localparam int DEF_SKEW_MAX       = 4;
  localparam int DEF_RECOVER_CYCLES = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/csi_rx_timer.sv
// Loadable down-counter that parks at zero; expired is high while the count is zero.
module csi_rx_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             areset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/csi_rx_link_ctrl.sv
// Link bring-up, watchdog and recovery sequencer for a CSI-2 receive datapath.
module csi_rx_link_ctrl
  import csi_rx_pkg::*;
#(
  parameter int LANES          = DEF_LANES,
  parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES,
  parameter int LP_MIN         = DEF_LP_MIN,
  parameter int SYNC_TIMEOUT   = DEF_SYNC_TIMEOUT,
  parameter int SKEW_MAX       = DEF_SKEW_MAX,
  parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
  input  logic             clock,
  input  logic             areset_n,
  input  logic             enable,
  input  logic             lp_detect,
  input  logic [LANES-1:0] aligned_valid,
  input  logic             wait_for_sync,
  input  logic             packet_done,
  input  logic             vsync,
  output logic             dp_reset,
  output logic             dp_enable,
  output logic             link_up,
  output logic [2:0]       state,
  output logic [15:0]      resync_count,
  output logic [15:0]      frame_count
);

  localparam int CYC_W = $clog2(max2(STARTUP_CYCLES, RECOVER_CYCLES) + 1);
  localparam int WD_W  = $clog2(SYNC_TIMEOUT + 1);
  localparam int LP_W  = $clog2(LP_MIN + 1);
  localparam int SK_W  = $clog2(SKEW_MAX + 1);

  // Timers hold N-1 so that a state lasts exactly N cycles including its entry cycle.
  localparam logic [CYC_W-1:0] CYC_STARTUP = CYC_W'(STARTUP_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_RECOVER = CYC_W'(RECOVER_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_RELOAD   = WD_W'(SYNC_TIMEOUT - 1);
  localparam logic [LP_W-1:0]  LP_LAST     = LP_W'(LP_MIN - 1);
  localparam logic [SK_W-1:0]  SKEW_LAST   = SK_W'(SKEW_MAX - 1);

  link_state_t      state_q, state_d;
  logic [LP_W-1:0]  lp_cnt;
  logic [SK_W-1:0]  skew_cnt;
  logic             cyc_load, cyc_expired;
  logic [CYC_W-1:0] cyc_value;
  logic             wd_load, wd_expired;
  logic             skewed, go_recover;

  assign skewed = !wait_for_sync && (aligned_valid != '0) && (aligned_valid != '1);

  csi_rx_timer #(.WIDTH(CYC_W)) u_cycle_timer (
    .clock    (clock),
    .areset_n (areset_n),
    .load     (cyc_load),
    .value    (cyc_value),
    .expired  (cyc_expired)
  );

  csi_rx_timer #(.WIDTH(WD_W)) u_watchdog (
    .clock    (clock),
    .areset_n (areset_n),
    .load     (wd_load),
    .value    (WD_RELOAD),
    .expired  (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    cyc_load   = 1'b0;
    cyc_value  = CYC_STARTUP;
    wd_load    = 1'b0;
    go_recover = 1'b0;
    if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d  = ST_STARTUP;
          cyc_load = 1'b1;
        end
        ST_STARTUP: if (cyc_expired) state_d = ST_WAIT_LP;
        ST_WAIT_LP: begin
          if (lp_detect && lp_cnt == LP_LAST) begin
            state_d = ST_ARMED;
            wd_load = 1'b1;
          end
        end
        ST_ARMED: begin
          if (packet_done) begin
            state_d = ST_ACTIVE;
            wd_load = 1'b1;
          end else if (wd_expired) begin
            go_recover = 1'b1;
          end
        end
        // Skew loss beats a keep-alive; a keep-alive beats a coincident watchdog expiry.
        ST_ACTIVE: begin
          if (skewed && skew_cnt == SKEW_LAST) go_recover = 1'b1;
          else if (packet_done)                wd_load    = 1'b1;
          else if (wd_expired)                 go_recover = 1'b1;
        end
        ST_RECOVER: if (cyc_expired) state_d = ST_WAIT_LP;
        default: state_d = ST_OFF;
      endcase
      if (go_recover) begin
        state_d   = ST_RECOVER;
        cyc_load  = 1'b1;
        cyc_value = CYC_RECOVER;
      end
    end
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      lp_cnt   <= '0;
      skew_cnt <= '0;
    end else begin
      lp_cnt   <= (state_q == ST_WAIT_LP && state_d == ST_WAIT_LP && lp_detect)
                  ? lp_cnt + 1'b1 : '0;
      skew_cnt <= (state_q == ST_ACTIVE && state_d == ST_ACTIVE && skewed)
                  ? skew_cnt + 1'b1 : '0;
    end
  end

  // Outputs are registered from the next state so they always match the state register.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= ST_OFF;
      dp_reset     <= 1'b1;
      dp_enable    <= 1'b0;
      link_up      <= 1'b0;
      resync_count <= '0;
      frame_count  <= '0;
    end else begin
      state_q   <= state_d;
      dp_reset  <= (state_d == ST_OFF) || (state_d == ST_STARTUP) || (state_d == ST_RECOVER);
      dp_enable <= (state_d == ST_ARMED) || (state_d == ST_ACTIVE);
      link_up   <= (state_d == ST_ACTIVE);
      if (state_d == ST_RECOVER && state_q != ST_RECOVER && resync_count != 16'hFFFF)
        resync_count <= resync_count + 16'd1;
      if (state_q == ST_OFF && state_d == ST_STARTUP)
        frame_count <= '0;
      else if (state_q == ST_ACTIVE && vsync)
        frame_count <= frame_count + 16'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_csi_rx_link_ctrl.sv
// Scoreboard bench for csi_rx_link_ctrl: expected outputs are queued per driven cycle and checked after the edge.
module tb_csi_rx_link_ctrl;
  import csi_rx_pkg::*;

  localparam int LANES          = 2;
  localparam int STARTUP_CYCLES = 16;
  localparam int LP_MIN         = 4;
  localparam int SYNC_TIMEOUT   = 100;
  localparam int SKEW_MAX       = 4;
  localparam int RECOVER_CYCLES = 8;

  logic             clock = 1'b0;
  logic             areset_n = 1'b0;
  logic             enable = 1'b0;
  logic             lp_detect = 1'b0;
  logic [LANES-1:0] aligned_valid = 2'b11;
  logic             wait_for_sync = 1'b0;
  logic             packet_done = 1'b0;
  logic             vsync = 1'b0;
  logic             dp_reset, dp_enable, link_up;
  logic [2:0]       state;
  logic [15:0]      resync_count, frame_count;

  typedef struct {
    string       tag;
    link_state_t st;
    logic [15:0] resync;
    logic [15:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_resync = 16'd0;
  logic [15:0] exp_frame  = 16'd0;

  csi_rx_link_ctrl #(
    .LANES          (LANES),
    .STARTUP_CYCLES (STARTUP_CYCLES),
    .LP_MIN         (LP_MIN),
    .SYNC_TIMEOUT   (SYNC_TIMEOUT),
    .SKEW_MAX       (SKEW_MAX),
    .RECOVER_CYCLES (RECOVER_CYCLES)
  ) dut (
    .clock         (clock),
    .areset_n      (areset_n),
    .enable        (enable),
    .lp_detect     (lp_detect),
    .aligned_valid (aligned_valid),
    .wait_for_sync (wait_for_sync),
    .packet_done   (packet_done),
    .vsync         (vsync),
    .dp_reset      (dp_reset),
    .dp_enable     (dp_enable),
    .link_up       (link_up),
    .state         (state),
    .resync_count  (resync_count),
    .frame_count   (frame_count)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic push_expect(input string tag, input link_state_t st);
    exp_t e;
    e.tag    = tag;
    e.st     = st;
    e.resync = exp_resync;
    e.frame  = exp_frame;
    exp_q.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    logic exp_rst, exp_en, exp_up;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e       = exp_q.pop_front();
    exp_rst = (e.st == ST_OFF) || (e.st == ST_STARTUP) || (e.st == ST_RECOVER);
    exp_en  = (e.st == ST_ARMED) || (e.st == ST_ACTIVE);
    exp_up  = (e.st == ST_ACTIVE);
    checkOutput({e.tag, ".state"},        32'(state),        32'(e.st));
    checkOutput({e.tag, ".dp_reset"},     32'(dp_reset),     32'(exp_rst));
    checkOutput({e.tag, ".dp_enable"},    32'(dp_enable),    32'(exp_en));
    checkOutput({e.tag, ".link_up"},      32'(link_up),      32'(exp_up));
    checkOutput({e.tag, ".resync_count"}, 32'(resync_count), 32'(e.resync));
    checkOutput({e.tag, ".frame_count"},  32'(frame_count),  32'(e.frame));
  endtask

  // One clock with the inputs currently driven; st is the state expected after the edge.
  task automatic applyStimulus(input string tag, input link_state_t st);
    push_expect(tag, st);
    @(negedge clock);
    compare_head();
  endtask

  task automatic check_now(input string tag, input link_state_t st);
    push_expect(tag, st);
    compare_head();
  endtask

  task automatic run_n(input string tag, input link_state_t st, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, st);
  endtask

  task automatic pulse_packet_done(input string tag, input link_state_t st);
    packet_done = 1'b1;
    applyStimulus(tag, st);
    packet_done = 1'b0;
  endtask

  task automatic bring_up(input string tag);
    enable    = 1'b1;
    lp_detect = 1'b1;
    run_n({tag, ".startup"}, ST_STARTUP, STARTUP_CYCLES);
    run_n({tag, ".wait_lp"}, ST_WAIT_LP, LP_MIN);
    applyStimulus({tag, ".armed"}, ST_ARMED);
  endtask

  // From the RECOVER entry edge: remaining RECOVER cycles, then WAIT_LP, then ARMED with lp_detect held.
  task automatic finish_recovery(input string tag);
    aligned_valid = 2'b11;
    lp_detect     = 1'b1;
    run_n({tag, ".recover"}, ST_RECOVER, RECOVER_CYCLES - 1);
    run_n({tag, ".wait_lp"}, ST_WAIT_LP, LP_MIN);
    applyStimulus({tag, ".armed"}, ST_ARMED);
  endtask

  initial begin
    @(negedge clock);
    check_now("reset", ST_OFF);
    areset_n = 1'b1;
    applyStimulus("off_idle", ST_OFF);

    bring_up("bringup");

    vsync = 1'b1;
    applyStimulus("armed_vsync_ignored", ST_ARMED);
    vsync = 1'b0;
    run_n("armed_wait", ST_ARMED, 47);
    pulse_packet_done("go_active", ST_ACTIVE);

    for (int i = 0; i < 3; i++) begin
      vsync = 1'b1;
      exp_frame++;
      applyStimulus("frame_vsync", ST_ACTIVE);
      vsync = 1'b0;
      applyStimulus("frame_gap", ST_ACTIVE);
    end

    pulse_packet_done("wd_reload", ST_ACTIVE);
    run_n("wd_running", ST_ACTIVE, SYNC_TIMEOUT - 1);
    exp_resync = 16'd1;
    applyStimulus("wd_expire", ST_RECOVER);
    aligned_valid = 2'b11;
    lp_detect     = 1'b1;
    run_n("wd_recover", ST_RECOVER, RECOVER_CYCLES - 1);
    applyStimulus("wd_wait_lp_entry", ST_WAIT_LP);

    lp_detect = 1'b1; run_n("lp_run1", ST_WAIT_LP, 3);
    lp_detect = 1'b0; applyStimulus("lp_drop", ST_WAIT_LP);
    lp_detect = 1'b1; run_n("lp_run2", ST_WAIT_LP, 3);
    applyStimulus("lp_armed", ST_ARMED);
    pulse_packet_done("skew_active", ST_ACTIVE);

    aligned_valid = 2'b01; wait_for_sync = 1'b1;
    run_n("skew_masked_by_wfs", ST_ACTIVE, 5);
    wait_for_sync = 1'b0;
    run_n("skew_run_a", ST_ACTIVE, SKEW_MAX - 1);
    aligned_valid = 2'b00; applyStimulus("skew_clear_zero", ST_ACTIVE);
    aligned_valid = 2'b10; run_n("skew_run_b", ST_ACTIVE, SKEW_MAX - 1);
    aligned_valid = 2'b11; applyStimulus("skew_clear_ones", ST_ACTIVE);
    aligned_valid = 2'b01; run_n("skew_run_c", ST_ACTIVE, SKEW_MAX - 1);
    exp_resync = 16'd2;
    applyStimulus("skew_trip", ST_RECOVER);
    finish_recovery("skew_rec");

    pulse_packet_done("coinc_active", ST_ACTIVE);
    run_n("coinc_running", ST_ACTIVE, SYNC_TIMEOUT - 1);
    pulse_packet_done("coinc_pd_wins", ST_ACTIVE);
    run_n("coinc_running2", ST_ACTIVE, SYNC_TIMEOUT - 1);
    enable = 1'b0;
    applyStimulus("coinc_disable_wins", ST_OFF);
    applyStimulus("coinc_off_hold", ST_OFF);

    exp_frame = 16'd0;
    bring_up("rebringup");
    pulse_packet_done("re_active", ST_ACTIVE);
    vsync = 1'b1; exp_frame = 16'd1;
    applyStimulus("re_vsync", ST_ACTIVE);
    vsync = 1'b0;

    force dut.resync_count = 16'hFFFF;
    #1;
    release dut.resync_count;
    exp_resync = 16'hFFFF;
    applyStimulus("sat_hold", ST_ACTIVE);
    aligned_valid = 2'b01; wait_for_sync = 1'b0;
    run_n("sat_skew", ST_ACTIVE, SKEW_MAX - 1);
    applyStimulus("sat_trip", ST_RECOVER);
    finish_recovery("sat_rec");
    pulse_packet_done("rst_active", ST_ACTIVE);

    #2;
    areset_n = 1'b0;
    #1;
    exp_resync = 16'd0;
    exp_frame  = 16'd0;
    check_now("async_reset", ST_OFF);
    @(negedge clock);
    check_now("reset_held", ST_OFF);
    areset_n = 1'b1;
    enable   = 1'b0;
    applyStimulus("post_reset_off", ST_OFF);
    enable = 1'b1;
    applyStimulus("post_reset_startup", ST_STARTUP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
